// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory-port arbiter: state encoding, owner ids,
// default widths and the legal latency range.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int MEM_LAT_DEF = 2;
  localparam int CNT_W       = 4;
  localparam int LAT_MIN     = 1;
  localparam int LAT_MAX     = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  function automatic logic lat_ok(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: under contention the requester that did not
// own the port last time wins.
module rr_pick2
  import cpu_mem_pkg::*;
(
  input  logic req_if,
  input  logic req_d,
  input  logic last_owner,
  output logic win_valid,
  output logic win_owner
);

  always_comb begin
    win_valid = req_if | req_d;
    win_owner = OWN_IF;
    if (req_if && req_d) begin
      win_owner = ~last_owner;
    end else if (req_d) begin
      win_owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data
// access, sequencing each access through issue, wait and response phases.
//
// state | meaning
// IDLE  | port free; requests arbitrated, winner's addr/we/wdata latched
// ISSUE | one-cycle mem_en strobe, grant pulse to owner, latency counter loaded
// WAIT  | MEM_LAT cycles; read data captured when the counter reaches 1
// RESP  | one-cycle valid pulse to owner, then back to IDLE
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              r_last_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_win_valid;
  logic              w_win_owner;
  logic              w_cnt_last;

  rr_pick2 u_pick (
    .req_if    (if_req),
    .req_d     (d_req),
    .last_owner(r_last_owner),
    .win_valid (w_win_valid),
    .win_owner (w_win_owner)
  );

  assign w_cnt_last = (r_cnt == CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= OWN_IF;
      r_last_owner <= OWN_IF;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_win_valid) begin
            r_owner <= w_win_owner;
            if (w_win_owner == OWN_D) begin
              r_addr  <= d_addr;
              r_we    <= d_we;
              r_wdata <= d_wdata;
            end else begin
              r_addr  <= if_addr;
              r_we    <= 1'b0;
              r_wdata <= '0;
            end
          end
        end
        ISSUE: begin
          r_last_owner <= r_owner;
          r_cnt        <= LAT_LOAD;
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_ONE;
          // Stores never touch the response registers.
          if (w_cnt_last && !r_we) begin
            if (r_owner == OWN_D) begin
              r_d_rdata <= mem_rdata;
            end else begin
              r_if_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_en      = 1'b0;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    if_valid    = 1'b0;
    d_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_valid) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_en      = 1'b1;
        if_gnt      = (r_owner == OWN_IF);
        d_gnt       = (r_owner == OWN_D);
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_cnt_last) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if_valid    = (r_owner == OWN_IF);
        d_valid     = (r_owner == OWN_D);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mem_we    = mem_en & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != IDLE);

  // The 4-bit counter cannot represent latencies outside 1..15.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (lat_ok(MEM_LAT))
        else $error("mem_port_arbiter: MEM_LAT=%0d outside %0d..%0d", MEM_LAT, LAT_MIN, LAT_MAX);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps on a MEM_LAT=2 instance, latency
// corner instances (1 and 15), then random traffic against a cycle-count model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  logic        x_req = 0;
  logic [31:0] x_addr = 0;
  logic        tie0 = 0;
  logic [31:0] tie0w = 0;
  logic [31:0] mr1 = 0, mr15 = 0;
  logic        u1_if_gnt, u1_if_valid, u1_d_gnt, u1_d_valid, u1_mem_en, u1_mem_we, u1_busy;
  logic [31:0] u1_if_rdata, u1_d_rdata, u1_mem_addr, u1_mem_wdata;
  logic        u15_if_gnt, u15_if_valid, u15_d_gnt, u15_d_valid, u15_mem_en, u15_mem_we, u15_busy;
  logic [31:0] u15_if_rdata, u15_d_rdata, u15_mem_addr, u15_mem_wdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(x_req), .if_addr(x_addr), .if_gnt(u1_if_gnt), .if_rdata(u1_if_rdata), .if_valid(u1_if_valid),
    .d_req(tie0), .d_we(tie0), .d_addr(tie0w), .d_wdata(tie0w),
    .d_gnt(u1_d_gnt), .d_rdata(u1_d_rdata), .d_valid(u1_d_valid),
    .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
    .mem_rdata(mr1), .busy(u1_busy));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n),
    .if_req(x_req), .if_addr(x_addr), .if_gnt(u15_if_gnt), .if_rdata(u15_if_rdata), .if_valid(u15_if_valid),
    .d_req(tie0), .d_we(tie0), .d_addr(tie0w), .d_wdata(tie0w),
    .d_gnt(u15_d_gnt), .d_rdata(u15_d_rdata), .d_valid(u15_d_valid),
    .mem_en(u15_mem_en), .mem_we(u15_mem_we), .mem_addr(u15_mem_addr), .mem_wdata(u15_mem_wdata),
    .mem_rdata(mr15), .busy(u15_busy));

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'h8C220004;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory models: data is correct only in the single cycle LAT after mem_en,
  // random junk in every other cycle.
  int m0_cnt = -1, m1_cnt = -1, m15_cnt = -1;
  logic [31:0] m0_a = 0, m1_a = 0, m15_a = 0;
  int en_cnt = 0, g_cnt = 0;

  always @(negedge clk) begin
    if (mem_en) begin m0_cnt = LAT; m0_a = mem_addr; en_cnt++; end
    if (if_gnt || d_gnt) g_cnt++;
    if (u1_mem_en) begin m1_cnt = 1; m1_a = u1_mem_addr; end
    if (u15_mem_en) begin m15_cnt = 15; m15_a = u15_mem_addr; end
  end

  always @(posedge clk) begin
    #1;
    if (m0_cnt >= 0) m0_cnt--;
    if (m1_cnt >= 0) m1_cnt--;
    if (m15_cnt >= 0) m15_cnt--;
    mem_rdata = (m0_cnt == 0) ? mem_fn(m0_a) : $urandom;
    mr1       = (m1_cnt == 0) ? mem_fn(m1_a) : $urandom;
    mr15      = (m15_cnt == 0) ? mem_fn(m15_a) : $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0: return if_gnt;
      1: return d_gnt;
      2: return if_valid;
      3: return d_valid;
      4: return u1_if_valid;
      5: return u15_if_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int w, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel(w) && n < limit);
    total++;
    assert (sel(w))
      else begin
        bad++;
        $error("FAIL %s_timeout observed=0 expected=1 after %0d cycles", tag, n);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int t0, t1, e0, g0, nv;
  bit own, last, g, v, e_we, if_won, d_won;
  int free_at, gnt_at, val_at;
  logic [31:0] e_addr, e_wdata, rd_if, rd_d;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk);

    // Single fetch
    #1; if_req = 1; if_addr = 32'h100; t0 = cyc;
    @(negedge clk);
    chk("f_idle_busy", busy, 0);
    wait_for("f_gnt", 0, 10);
    chk("f_gnt_cyc", cyc - t0, 1);
    chk("f_mem_en", mem_en, 1);
    chk("f_mem_we", mem_we, 0);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_d_gnt", d_gnt, 0);
    @(posedge clk); #1 if_req = 0;
    @(negedge clk);
    chk("f_mem_en_once", mem_en, 0);
    wait_for("f_valid", 2, 10);
    chk("f_valid_cyc", cyc - t0, 4);
    chk("f_rdata", if_rdata, 32'h8C220004);
    chk("f_d_valid", d_valid, 0);
    @(negedge clk);
    chk("f_valid_pulse", if_valid, 0);
    chk("f_rdata_hold", if_rdata, 32'h8C220004);
    chk("f_busy_end", busy, 0);

    // Single store
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; t0 = cyc;
    wait_for("s_gnt", 1, 10);
    chk("s_gnt_cyc", cyc - t0, 1);
    chk("s_mem_en", mem_en, 1);
    chk("s_mem_we", mem_we, 1);
    chk("s_mem_addr", mem_addr, 32'h2000);
    chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("s_if_gnt", if_gnt, 0);
    @(posedge clk); #1 d_req = 0; d_we = 0;
    wait_for("s_valid", 3, 10);
    chk("s_valid_cyc", cyc - t0, 4);
    chk("s_d_rdata_kept", d_rdata, 0);
    chk("s_if_valid", if_valid, 0);
    chk("s_if_rdata_kept", if_rdata, 32'h8C220004);

    // Contention from reset: data, IF, data, IF
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1;
    if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h400; t0 = cyc;
    wait_for("c1_gnt", 1, 10);
    chk("c1_gnt_cyc", cyc - t0, 1);
    chk("c1_if_gnt", if_gnt, 0);
    @(posedge clk); #1 d_req = 0;
    wait_for("c1_valid", 3, 10);
    chk("c1_valid_cyc", cyc - t0, 4);
    chk("c1_d_rdata", d_rdata, mem_fn(32'h400));
    chk("c1_if_valid", if_valid, 0);
    wait_for("c2_gnt", 0, 10);
    chk("c2_gnt_cyc", cyc - t0, 6);
    @(posedge clk); #1;
    if_addr = 32'h304; d_req = 1; d_addr = 32'h404; t1 = cyc;
    wait_for("c2_valid", 2, 10);
    chk("c2_valid_cyc", cyc - t1, 2);
    chk("c2_if_rdata", if_rdata, mem_fn(32'h300));
    wait_for("c3_gnt", 1, 10);
    chk("c3_gnt_cyc", cyc - t1, 4);
    chk("c3_if_gnt", if_gnt, 0);
    @(posedge clk); #1 d_req = 0;
    wait_for("c3_valid", 3, 10);
    chk("c3_valid_cyc", cyc - t1, 7);
    chk("c3_d_rdata", d_rdata, mem_fn(32'h404));
    wait_for("c4_gnt", 0, 10);
    chk("c4_gnt_cyc", cyc - t1, 9);
    chk("c4_mem_addr", mem_addr, 32'h304);
    @(posedge clk); #1 if_req = 0;
    wait_for("c4_valid", 2, 10);
    chk("c4_valid_cyc", cyc - t1, 12);
    chk("c4_if_rdata", if_rdata, mem_fn(32'h304));

    // Latency corners 1 and 15
    @(posedge clk); #1; x_req = 1; x_addr = 32'h40; t0 = cyc;
    @(negedge clk); @(negedge clk);
    chk("l1_gnt", u1_if_gnt, 1);
    chk("l15_gnt", u15_if_gnt, 1);
    @(posedge clk); #1 x_req = 0;
    wait_for("l1_valid", 4, 30);
    chk("l1_valid_cyc", cyc - t0, 3);
    chk("l1_rdata", u1_if_rdata, mem_fn(32'h40));
    wait_for("l15_valid", 5, 30);
    chk("l15_valid_cyc", cyc - t0, 17);
    chk("l15_rdata", u15_if_rdata, mem_fn(32'h40));

    // Reset during WAIT aborts the fetch
    @(posedge clk); #1; if_req = 1; if_addr = 32'h500;
    wait_for("r_gnt", 0, 10);
    @(posedge clk); #1 if_req = 0;
    @(negedge clk);
    chk("r_busy_wait", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("r_busy_async", busy, 0);
    chk("r_mem_en_async", mem_en, 0);
    chk("r_gnt_async", if_gnt, 0);
    chk("r_valid_async", if_valid, 0);
    chk("r_rdata_async", if_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_valid || d_valid) nv++;
    end
    chk("r_no_valid", nv, 0);
    @(posedge clk); #1; d_req = 1; d_we = 0; d_addr = 32'h600; t0 = cyc;
    wait_for("r2_gnt", 1, 10);
    @(posedge clk); #1 d_req = 0;
    wait_for("r2_valid", 3, 10);
    chk("r2_valid_cyc", cyc - t0, 4);
    chk("r2_d_rdata", d_rdata, mem_fn(32'h600));

    // Held request re-issues after one IDLE cycle
    @(posedge clk); #1; d_req = 1; d_we = 0; d_addr = 32'h700; t0 = cyc;
    e0 = en_cnt; g0 = g_cnt;
    wait_for("h1_gnt", 1, 10);
    chk("h1_gnt_cyc", cyc - t0, 1);
    wait_for("h1_valid", 3, 10);
    chk("h1_valid_cyc", cyc - t0, 4);
    wait_for("h2_gnt", 1, 10);
    chk("h2_gnt_cyc", cyc - t0, 6);
    chk("h2_mem_addr", mem_addr, 32'h700);
    @(posedge clk); #1 d_req = 0;
    wait_for("h2_valid", 3, 10);
    chk("h2_valid_cyc", cyc - t0, 9);
    chk("h2_d_rdata", d_rdata, mem_fn(32'h700));
    chk("h_en_count", en_cnt - e0, 2);
    chk("h_gnt_count", g_cnt - g0, 2);

    // Random traffic against a cycle-count model
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    last = 0; own = 0; e_we = 0; e_addr = 0; e_wdata = 0;
    free_at = 0; gnt_at = -1; val_at = -1; rd_if = 0; rd_d = 0;
    if_won = 0; d_won = 0;
    @(negedge clk);
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (!if_req || if_won) begin
        if_req  = ($urandom_range(0, 2) == 0);
        if_addr = 32'($urandom_range(0, 1023)) << 2;
      end
      if (!d_req || d_won) begin
        d_req   = ($urandom_range(0, 2) == 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'($urandom_range(0, 1023)) << 2;
        d_wdata = $urandom;
      end
      @(negedge clk);
      g = (cyc == gnt_at);
      v = (cyc == val_at);
      chk("rnd_if_gnt", if_gnt, g && !own);
      chk("rnd_d_gnt", d_gnt, g && own);
      chk("rnd_mem_en", mem_en, g);
      if (g) begin
        chk("rnd_mem_we", mem_we, e_we);
        chk("rnd_mem_addr", mem_addr, e_addr);
        if (e_we) chk("rnd_mem_wdata", mem_wdata, e_wdata);
      end
      if (v && !e_we) begin
        if (own) rd_d = mem_fn(e_addr);
        else     rd_if = mem_fn(e_addr);
      end
      chk("rnd_if_valid", if_valid, v && !own);
      chk("rnd_d_valid", d_valid, v && own);
      chk("rnd_if_rdata", if_rdata, rd_if);
      chk("rnd_d_rdata", d_rdata, rd_d);
      chk("rnd_busy", busy, cyc < free_at);
      if_won = g && !own;
      d_won  = g && own;
      if (cyc >= free_at && (if_req || d_req)) begin
        own     = (if_req && d_req) ? !last : d_req;
        last    = own;
        e_addr  = own ? d_addr : if_addr;
        e_we    = own && d_we;
        e_wdata = d_wdata;
        gnt_at  = cyc + 1;
        val_at  = cyc + LAT + 2;
        free_at = cyc + LAT + 3;
      end
    end
    if_req = 0; d_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
